uart_tx_queue: RTL

Buffered transmit front-end that sits between game logic and the UART transmit interface (send/txdata/txdone). Game logic writes bytes at any rate up to the queue depth. The block drains them one frame at a time: it issues a send pulse with the byte, then waits for txdone before issuing the next. It is the writer side of the UART transmit handshake, so producers never have to sequence frames themselves.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_queue_mem.sv | 28 ++
 rtl/uart_tx_queue.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit queue: byte width and FSM state codes.
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;

endpackage

// File: rtl/uart_tx_queue_mem.sv
// Byte storage for the transmit queue: synchronous write, asynchronous read.
// Holds payload only, so it carries no reset.
module uart_tx_queue_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Store an accepted byte at the write pointer.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered UART transmit front-end: queues bytes from the producer and drains
// them one frame at a time through the send/txdata/txdone handshake.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int GAP    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              busy,
  output logic              send,
  output logic [BYTE_W-1:0] txdata,
  input  logic              txdone
);

  localparam int              GW        = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]   GAP_LAST  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  logic [2:0]        state;
  logic [GW-1:0]     gcnt;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W-1:0] rp;
  logic [ADDR_W:0]   count_nxt;
  logic [BYTE_W-1:0] rd_data;
  logic              wr_ok;
  logic              pop;

  // full is a registered flag, so a write while full is dropped even when a
  // pop frees a slot in the same cycle.
  assign wr_ok = wr_en && !full;
  assign pop   = (state == ST_IDLE) && !empty;
  assign send  = (state == ST_SEND);
  assign busy  = (state != ST_IDLE) || !empty;

  uart_tx_queue_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clock(clock),
    .we   (wr_ok),
    .waddr(wp),
    .wdata(wr_data),
    .raddr(rp),
    .rdata(rd_data)
  );

  // Next occupancy: a simultaneous write and pop leaves count unchanged.
  always_comb begin
    count_nxt = count;
    if (wr_ok && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!wr_ok && pop) begin
      count_nxt = count - 1'b1;
    end
  end

  // Queue pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr_ok) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

  // Sticky overflow flag; a dropped write wins over a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Frame sequencer: pop, settle, pulse send, wait for txdone, then idle gap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      gcnt   <= '0;
      txdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            txdata <= rd_data;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: state <= ST_SEND;
        ST_SEND: state <= ST_WAIT;
        ST_WAIT: begin
          if (txdone) begin
            gcnt <= '0;
            if (GAP == 0) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gcnt == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
